register_file_2r1w: RTL and testbench

//  Parametrised 2-read/1-write register file for the sCPU datapath; generalises the single
//  4-bit enable register to DEPTH words of WIDTH bits. Adds a per-register pending scoreboard:

---
 rtl/register_file_2r1w.sv | 81 ++++++++
 tb/tb_register_file_2r1w.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file_2r1w.sv
// 2-read/1-write register file with a per-register pending scoreboard (reserve at decode, clear at writeback).
// Optional `REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module register_file_2r1w #(
  parameter int WIDTH    = 4,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0,
  localparam int DEPTH   = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  output logic              pend_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              pend_b,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ready,
  output logic [DEPTH-1:0]  pending
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  function automatic logic hw_zero(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // A write landing on the reserved address this cycle frees the slot for a new reservation.
  assign rsv_ready = hw_zero(rsv_addr) | ~pending_q[rsv_addr] | (we && (waddr == rsv_addr));
  assign pending   = pending_q;

  always_comb begin
    mem_d     = mem_q;
    pending_d = pending_q;
    if (we && !hw_zero(waddr)) begin
      mem_d[waddr]     = wdata;
      pending_d[waddr] = 1'b0;
    end
    // Applied after the write so a same-address reservation leaves the register pending.
    if (rsv_valid && rsv_ready && !hw_zero(rsv_addr)) begin
      pending_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      mem_q     <= mem_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    rdata_a = hw_zero(raddr_a) ? '0 : mem_q[raddr_a];
    pend_a  = hw_zero(raddr_a) ? 1'b0 : pending_q[raddr_a];
    rdata_b = hw_zero(raddr_b) ? '0 : mem_q[raddr_b];
    pend_b  = hw_zero(raddr_b) ? 1'b0 : pending_q[raddr_b];
`ifdef REGFILE_BYPASS_EN
    if (we && (waddr == raddr_a) && !hw_zero(raddr_a)) begin
      rdata_a = wdata;
      pend_a  = 1'b0;
    end
    if (we && (waddr == raddr_b) && !hw_zero(raddr_b)) begin
      rdata_b = wdata;
      pend_b  = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Bench for register_file_2r1w: two instances (plain and hardwired-zero) share stimulus and are
// checked every cycle against an array-based model, plus directed literal expectations.
module tb_register_file_2r1w;

  logic       clk = 1'b0;
  logic       rst, we, rsv_valid;
  logic [1:0] waddr, raddr_a, raddr_b, rsv_addr;
  logic [3:0] wdata;

  logic [3:0] rda0, rdb0, pnd0, rda1, rdb1, pnd1;
  logic       pa0, pb0, rr0, pa1, pb1, rr1;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // model state: index 0 = plain instance, 1 = hardwired-zero instance
  logic [3:0] m_reg [2][4];
  bit         m_pnd [2][4];

  always #5 clk = ~clk;

  register_file_2r1w #(.WIDTH(4), .ADDR_W(2), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rda0), .pend_a(pa0),
    .raddr_b(raddr_b), .rdata_b(rdb0), .pend_b(pb0),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rr0), .pending(pnd0));

  register_file_2r1w #(.WIDTH(4), .ADDR_W(2), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rda1), .pend_a(pa1),
    .raddr_b(raddr_b), .rdata_b(rdb1), .pend_b(pb1),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rr1), .pending(pnd1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_hz(input int d, input logic [1:0] a);
    return (d == 1) && (a == 2'd0);
  endfunction

  function automatic logic [3:0] m_rdata(input int d, input logic [1:0] a);
    if (is_hz(d, a)) return 4'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && waddr == a) return wdata;
`endif
    return m_reg[d][a];
  endfunction

  function automatic bit m_pend(input int d, input logic [1:0] a);
    if (is_hz(d, a)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we && waddr == a) return 1'b0;
`endif
    return m_pnd[d][a];
  endfunction

  function automatic bit m_ready(input int d);
    if (is_hz(d, rsv_addr)) return 1'b1;
    return !m_pnd[d][rsv_addr] || (we && waddr == rsv_addr);
  endfunction

  function automatic logic [3:0] m_pvec(input int d);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_pnd[d][i];
    return v;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < 4; i++) begin
          m_reg[d][i] = 4'h0;
          m_pnd[d][i] = 1'b0;
        end
      end else begin
        bit acc;
        acc = rsv_valid && m_ready(d) && !is_hz(d, rsv_addr);
        if (we && !is_hz(d, waddr)) begin
          m_reg[d][waddr] = wdata;
          m_pnd[d][waddr] = 1'b0;
        end
        if (acc) m_pnd[d][rsv_addr] = 1'b1;
      end
    end
  end

  task automatic cmp_dut(input int d, input logic [3:0] ra, input logic pa, input logic [3:0] rb,
                         input logic pb, input logic rr, input logic [3:0] pv);
    chk($sformatf("dut%0d rdata_a", d), {28'd0, ra}, {28'd0, m_rdata(d, raddr_a)});
    chk($sformatf("dut%0d pend_a", d), {31'd0, pa}, {31'd0, m_pend(d, raddr_a)});
    chk($sformatf("dut%0d rdata_b", d), {28'd0, rb}, {28'd0, m_rdata(d, raddr_b)});
    chk($sformatf("dut%0d pend_b", d), {31'd0, pb}, {31'd0, m_pend(d, raddr_b)});
    chk($sformatf("dut%0d rsv_ready", d), {31'd0, rr}, {31'd0, m_ready(d)});
    chk($sformatf("dut%0d pending", d), {28'd0, pv}, {28'd0, m_pvec(d)});
  endtask

  always @(negedge clk) begin
    #2;
    if (cmp_en) begin
      cmp_dut(0, rda0, pa0, rdb0, pb0, rr0, pnd0);
      cmp_dut(1, rda1, pa1, rdb1, pb1, rr1, pnd1);
    end
  end

  task automatic drive(input logic r, input logic w, input logic [1:0] wa, input logic [3:0] wd,
                       input logic [1:0] ra, input logic [1:0] rb, input logic rv,
                       input logic [1:0] rsa);
    @(negedge clk);
    rst = r; we = w; waddr = wa; wdata = wd;
    raddr_a = ra; raddr_b = rb; rsv_valid = rv; rsv_addr = rsa;
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    raddr_a = '0; raddr_b = '0; rsv_valid = 1'b0; rsv_addr = '0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cmp_en = 1'b1;

    // random writes, then reset overriding a write and a reservation
    for (int i = 0; i < 6; i++)
      drive(0, 1, 2'($urandom_range(3)), 4'($urandom), 0, 0, 1, 2'($urandom_range(3)));
    drive(1, 1, 2, 4'h9, 0, 0, 1, 2);
    drive(0, 0, 0, 0, 2, 3, 0, 2);
    chk("reset rdata_a", {28'd0, rda0}, 32'h0);
    chk("reset rdata_b", {28'd0, rdb0}, 32'h0);
    chk("reset pending", {28'd0, pnd0}, 32'h0);
    chk("reset rsv_ready", {31'd0, rr0}, 32'h1);

    // plain write then read on both ports
    drive(0, 1, 2, 4'hA, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 2, 2, 0, 0);
    chk("wr2 rdata_a", {28'd0, rda0}, 32'hA);
    chk("wr2 rdata_b", {28'd0, rdb0}, 32'hA);

    // reserve 1, second reservation blocked, writeback clears
    drive(0, 0, 0, 0, 1, 0, 1, 1);
    chk("rsv1 ready", {31'd0, rr0}, 32'h1);
    drive(0, 0, 0, 0, 1, 0, 1, 1);
    chk("rsv1 pending", {28'd0, pnd0}, 32'h2);
    chk("rsv1 pend_a", {31'd0, pa0}, 32'h1);
    chk("rsv1 again ready", {31'd0, rr0}, 32'h0);
    drive(0, 1, 1, 4'h5, 1, 0, 0, 1);
    chk("rsv1 held pending", {28'd0, pnd0}, 32'h2);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    chk("wb1 pending", {28'd0, pnd0}, 32'h0);
    chk("wb1 rdata_a", {28'd0, rda0}, 32'h5);

    // write and re-reservation of the same pending register
    drive(0, 0, 0, 0, 3, 0, 1, 3);
    drive(0, 1, 3, 4'h7, 3, 0, 1, 3);
    chk("wr+rsv3 ready", {31'd0, rr0}, 32'h1);
    chk("wr+rsv3 pend before", {31'd0, pnd0[3]}, 32'h1);
    drive(0, 0, 0, 0, 3, 0, 0, 0);
    chk("wr+rsv3 rdata", {28'd0, rda0}, 32'h7);
    chk("wr+rsv3 pending", {31'd0, pnd0[3]}, 32'h1);
    drive(0, 1, 3, 4'h7, 0, 0, 0, 0);

    // same-cycle write/read of register 2 (holds A)
    drive(0, 1, 2, 4'hC, 2, 0, 0, 0);
`ifdef REGFILE_BYPASS_EN
    chk("bypass rdata_a", {28'd0, rda0}, 32'hC);
`else
    chk("nobypass rdata_a", {28'd0, rda0}, 32'hA);
`endif
    drive(0, 0, 0, 0, 2, 0, 0, 0);
    chk("after wr2 rdata_a", {28'd0, rda0}, 32'hC);

    // hardwired zero register vs plain register 0
    drive(0, 1, 0, 4'hF, 0, 0, 1, 0);
    chk("z0 ready same cycle", {31'd0, rr1}, 32'h1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    chk("z0 rdata_a", {28'd0, rda1}, 32'h0);
    chk("z0 pending0", {31'd0, pnd1[0]}, 32'h0);
    chk("z0 rsv_ready", {31'd0, rr1}, 32'h1);
    chk("plain r0 rdata_a", {28'd0, rda0}, 32'hF);
    chk("plain r0 pending0", {31'd0, pnd0[0]}, 32'h1);
    drive(1, 1, 2, 4'h9, 2, 2, 0, 0);
    drive(0, 0, 0, 0, 2, 2, 0, 0);
    chk("rst discards write dut0", {28'd0, rda0}, 32'h0);
    chk("rst discards write dut1", {28'd0, rdb1}, 32'h0);

    // randomized traffic; requester keeps its request until it sees ready
    for (int i = 0; i < 3000; i++) begin
      logic       rv;
      logic [1:0] ra;
      if (rsv_valid && !rr0) begin
        rv = 1'b1;
        ra = rsv_addr;
      end else begin
        rv = ($urandom_range(99) < 40);
        ra = 2'($urandom_range(3));
      end
      drive(($urandom_range(99) < 2), ($urandom_range(99) < 50), 2'($urandom_range(3)),
            4'($urandom), 2'($urandom_range(3)), 2'($urandom_range(3)), rv, ra);
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
